// File: rtl/avg_gear_ctrl.sv
// Gear-shift sequencer for the AGC DC-removal averager: clears the accumulator,
// steps the averaging shift from fast acquisition to tracking, re-acquires on mean jumps.
module avg_gear_ctrl #(
    parameter int DW        = 16,
    parameter int K_START   = 4,
    parameter int K_STEP    = 2,
    parameter int K_FINAL   = 10,
    parameter int DWELL     = 256,
    parameter int WIN       = 64,
    parameter int RETRIG_TH = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          start,
    input  logic          freeze,
    input  logic [DW-1:0] mean,
    output logic [3:0]    k_out,
    output logic          acc_clr,
    output logic          avg_ce,
    output logic          busy,
    output logic          settled,
    output logic          retrig,
    output logic [7:0]    retrig_cnt
);

    typedef enum logic [1:0] {IDLE, CLEAR, ACQ, TRACK} state_t;

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;

    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [WCW-1:0] WIN_LAST   = WCW'(WIN - 1);
    localparam logic [3:0]     K_START_L  = 4'(K_START);
    localparam logic [3:0]     K_FINAL_L  = 4'(K_FINAL);
    localparam logic [4:0]     K_FINAL_W  = 5'(K_FINAL);
    localparam logic [4:0]     K_STEP_W   = 5'(K_STEP);
    localparam logic [DW:0]    TH_W       = (DW+1)'(RETRIG_TH);

    state_t         state;
    logic [DCW-1:0] dwell_cnt;
    logic [WCW-1:0] win_cnt;
    logic [DW-1:0]  snap;

    logic           qual;
    logic [4:0]     k_sum;
    logic [3:0]     k_next;
    logic [DW:0]    diff;
    logic [DW:0]    mag;
    logic           jump;

    assign qual   = ce & ~freeze;
    assign avg_ce = qual;

    // Next gear, widened so K_FINAL near 15 cannot wrap the 4-bit shift.
    always_comb begin
        k_sum  = {1'b0, k_out} + K_STEP_W;
        k_next = (k_sum >= K_FINAL_W) ? K_FINAL_L : k_sum[3:0];
    end

    // One extra bit keeps |mean - snap| exact over the full signed range.
    always_comb begin
        diff = {mean[DW-1], mean} - {snap[DW-1], snap};
        mag  = diff[DW] ? (~diff + (DW+1)'(1)) : diff;
        jump = (mag > TH_W);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            k_out      <= K_START_L;
            acc_clr    <= 1'b0;
            busy       <= 1'b0;
            settled    <= 1'b0;
            retrig     <= 1'b0;
            retrig_cnt <= 8'd0;
            dwell_cnt  <= '0;
            win_cnt    <= '0;
            snap       <= '0;
        end else begin
            retrig <= 1'b0;
            if (start) begin
                state     <= CLEAR;
                k_out     <= K_START_L;
                acc_clr   <= 1'b1;
                busy      <= 1'b1;
                settled   <= 1'b0;
                dwell_cnt <= '0;
                win_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    CLEAR: begin
                        state   <= ACQ;
                        acc_clr <= 1'b0;
                    end
                    ACQ: begin
                        if (qual) begin
                            if (dwell_cnt == DWELL_LAST) begin
                                dwell_cnt <= '0;
                                k_out     <= k_next;
                                if (k_next == K_FINAL_L) begin
                                    state   <= TRACK;
                                    busy    <= 1'b0;
                                    settled <= 1'b1;
                                    snap    <= mean;
                                    win_cnt <= '0;
                                end
                            end else begin
                                dwell_cnt <= dwell_cnt + DCW'(1);
                            end
                        end
                    end
                    TRACK: begin
                        if (qual) begin
                            if (win_cnt == WIN_LAST) begin
                                win_cnt <= '0;
                                snap    <= mean;
                                // Re-acquire without clearing: the accumulator keeps its history.
                                if (jump) begin
                                    state      <= ACQ;
                                    k_out      <= K_START_L;
                                    busy       <= 1'b1;
                                    settled    <= 1'b0;
                                    retrig     <= 1'b1;
                                    dwell_cnt  <= '0;
                                    retrig_cnt <= (retrig_cnt != 8'hFF) ? retrig_cnt + 8'd1
                                                                        : retrig_cnt;
                                end
                            end else begin
                                win_cnt <= win_cnt + WCW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_avg_gear_ctrl.sv
// Directed bench for avg_gear_ctrl: per-cycle compare against a sample-count model,
// plus literal checkpoints along acquisition, freeze, re-acquisition and reset.
module tb_avg_gear_ctrl;

    localparam int DW = 16, KS = 4, KP = 2, KF = 10, DWL = 4, WN = 4, TH = 100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0, start = 1'b0, freeze = 1'b0;
    logic [DW-1:0] mean = '0;
    logic [3:0]  k_out;
    logic        acc_clr, avg_ce, busy, settled, retrig;
    logic [7:0]  retrig_cnt;

    int n_tests = 0, n_fail = 0;

    avg_gear_ctrl #(.DW(DW), .K_START(KS), .K_STEP(KP), .K_FINAL(KF),
                    .DWELL(DWL), .WIN(WN), .RETRIG_TH(TH)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .start(start), .freeze(freeze),
        .mean(mean), .k_out(k_out), .acc_clr(acc_clr), .avg_ce(avg_ce),
        .busy(busy), .settled(settled), .retrig(retrig), .retrig_cnt(retrig_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: modes 0 idle, 1 clear, 2 acquiring, 3 tracking; gear derives from sample count.
    int m_mode, m_acq_n, m_win_n, m_snap, m_cnt;
    bit m_retrig;

    function automatic int gear(input int n);
        int k;
        k = KS + KP * (n / DWL);
        return (k > KF) ? KF : k;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_acq_n = 0; m_win_n = 0; m_snap = 0; m_cnt = 0; m_retrig = 0;
        end else begin
            int mv, d;
            bit q;
            mv = int'($signed(mean));
            q = ce && !freeze;
            m_retrig = 0;
            if (start) begin
                m_mode = 1; m_acq_n = 0; m_win_n = 0;
            end else if (m_mode == 1) begin
                m_mode = 2;
            end else if (m_mode == 2 && q) begin
                m_acq_n++;
                if (m_acq_n % DWL == 0 && gear(m_acq_n) == KF) begin
                    m_mode = 3; m_snap = mv; m_win_n = 0;
                end
            end else if (m_mode == 3 && q) begin
                m_win_n++;
                if (m_win_n == WN) begin
                    m_win_n = 0;
                    d = (mv > m_snap) ? mv - m_snap : m_snap - mv;
                    m_snap = mv;
                    if (d > TH) begin
                        m_mode = 2; m_acq_n = 0; m_retrig = 1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end
        end
    end

    function automatic int exp_k();
        if (m_mode == 2) return gear(m_acq_n);
        if (m_mode == 3) return KF;
        return KS;
    endfunction

    always @(negedge clk) begin
        chk("k_out",      k_out,      exp_k());
        chk("acc_clr",    acc_clr,    int'(m_mode == 1));
        chk("busy",       busy,       int'(m_mode == 1 || m_mode == 2));
        chk("settled",    settled,    int'(m_mode == 3));
        chk("retrig",     retrig,     int'(m_retrig));
        chk("retrig_cnt", retrig_cnt, m_cnt);
        chk("avg_ce",     avg_ce,     int'(ce && !freeze));
    end

    // Inputs change 2 time units after the active edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        step(2);
        chk("rst_k", k_out, 4);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        ce = 1'b1;
        step(5);
        chk("idle_busy", busy, 0);
        chk("idle_k", k_out, 4);

        // Acquisition 4 -> 6 -> 8 -> 10
        start = 1'b1; step(1); start = 1'b0;
        chk("clr_pulse", acc_clr, 1);
        step(1);
        chk("clr_done", acc_clr, 0);
        chk("acq_busy", busy, 1);
        step(3);  chk("k_at3", k_out, 4);
        step(1);  chk("k_at4", k_out, 6);
        step(4);  chk("k_at8", k_out, 8);
        step(3);  chk("pre_settled", settled, 0);
        step(1);  chk("k_at12", k_out, 10);
        chk("settled", settled, 1);
        chk("trk_busy", busy, 0);

        // Re-acquisition on a 500 jump
        mean = 16'd500;
        step(3);  chk("no_retrig_yet", retrig, 0);
        step(1);
        chk("retrig", retrig, 1);
        chk("retrig_cnt1", retrig_cnt, 1);
        chk("reacq_k", k_out, 4);
        chk("reacq_settled", settled, 0);
        chk("reacq_noclr", acc_clr, 0);
        step(1);  chk("retrig_once", retrig, 0);
        step(10); chk("resettle_pre", settled, 0);
        step(1);  chk("resettle", settled, 1);

        // Jump of exactly the threshold does not retrigger
        mean = 16'd600;
        step(8);
        chk("small_cnt", retrig_cnt, 1);
        chk("small_settled", settled, 1);

        // start coincident with a retriggering window end
        mean = 16'd0;
        step(3);
        start = 1'b1; step(1); start = 1'b0;
        chk("sim_clr", acc_clr, 1);
        chk("sim_retrig", retrig, 0);
        chk("sim_cnt", retrig_cnt, 1);

        // Freeze mid-dwell at k=6
        step(1);
        step(4);  chk("frz_k6", k_out, 6);
        step(2);
        freeze = 1'b1; #1;
        chk("frz_avg_ce", avg_ce, 0);
        step(10); chk("frz_hold", k_out, 6);
        freeze = 1'b0;
        step(5);  chk("frz_pre", settled, 0);
        step(1);  chk("frz_settled", settled, 1);

        // start while frozen
        freeze = 1'b1; start = 1'b1; step(1); start = 1'b0;
        chk("fs_clr", acc_clr, 1);
        step(1);
        chk("fs_clr_end", acc_clr, 0);
        chk("fs_busy", busy, 1);
        step(8);  chk("fs_hold_k", k_out, 4);
        chk("fs_hold_busy", busy, 1);
        freeze = 1'b0;

        // Asynchronous reset mid-acquisition
        step(3);
        reset_n = 1'b0; #1;
        chk("ar_k", k_out, 4);
        chk("ar_busy", busy, 0);
        chk("ar_cnt", retrig_cnt, 0);
        chk("ar_settled", settled, 0);
        step(2);
        reset_n = 1'b1;
        step(3);
        chk("post_k", k_out, 4);
        chk("post_busy", busy, 0);
        chk("post_clr", acc_clr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
